// File: rtl/dff_xchecker_mc_if.sv
// Bundle of the checked write channels and the checker status outputs.
// The master side drives the observed write traffic and reads status;
// the slave side is the checker itself.
interface dff_xchecker_mc_if #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0]       wen;
  logic [CHANNELS*WIDTH-1:0] d;
  logic                      clr;

  logic                      armed;
  logic [CHANNELS-1:0]       err_vld;
  logic [CHANNELS*CNT_W-1:0] err_cnt;
  logic                      first_vld;
  logic [CH_W-1:0]           first_ch;

  modport master (
    output wen, d, clr,
    input  armed, err_vld, err_cnt, first_vld, first_ch
  );

  modport slave (
    input  wen, d, clr,
    output armed, err_vld, err_cnt, first_vld, first_ch
  );
endinterface

// File: rtl/dff_xchecker_mc.sv
// dff_xchecker_mc: simulation-only X/Z checker for a bank of write channels.
// After a warm-up window following reset release, every cycle each channel
// is inspected: an unknown write enable, or a known-high enable with unknown
// data, counts as a violation. Violations are kept as sticky flags,
// saturating counters and a first-error record, and each one is reported
// through the MCASH_ASSERT_ERROR macro. The block only observes; it drives
// nothing back into the design under check.
//
// state  | meaning
// WARMUP | counting down ARM_DLY cycles after reset release, checks suppressed
// CHECK  | checking active, held until the next reset

`ifndef MCASH_ASSERT_ERROR
`define MCASH_ASSERT_ERROR(msg) $warning("%s", msg)
`endif

module dff_xchecker_mc #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int ARM_DLY  = 4,
  parameter int CNT_W    = 8
) (
  input logic              clk,
  input logic              rst_n,
  dff_xchecker_mc_if.slave bus
);

  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int DLY_W = (ARM_DLY > 1) ? $clog2(ARM_DLY + 1) : 1;

  localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(ARM_DLY);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {
    WARMUP = 1'b0,
    CHECK  = 1'b1
  } state_t;

  // With no warm-up requested the checker comes out of reset already armed.
  localparam state_t RST_STATE = (ARM_DLY == 0) ? CHECK : WARMUP;

  state_t           state;
  state_t           state_nxt;
  logic [DLY_W-1:0] dly_cnt;
  logic [DLY_W-1:0] dly_cnt_nxt;
  logic             armed;

  logic [CHANNELS-1:0] viol;
  logic                clr_eff;
  logic                clr_unknown;

  logic [CHANNELS-1:0] vld_q;
  logic [CHANNELS-1:0] vld_nxt;
  logic [CNT_W-1:0]    cnt_q   [CHANNELS];
  logic [CNT_W-1:0]    cnt_nxt [CHANNELS];
  logic                first_vld_q;
  logic                first_vld_nxt;
  logic [CH_W-1:0]     first_ch_q;
  logic [CH_W-1:0]     first_ch_nxt;
  logic [CH_W-1:0]     low_idx;

  // FSM state register and warm-up down-counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RST_STATE;
      dly_cnt <= DLY_LOAD;
    end else begin
      state   <= state_nxt;
      dly_cnt <= dly_cnt_nxt;
    end
  end

  // Next state: leave WARMUP on the edge where the counter reads 1
  always_comb begin
    state_nxt   = state;
    dly_cnt_nxt = dly_cnt;
    case (state)
      WARMUP: begin
        // <= rather than == so a corrupted zero count cannot stall warm-up
        if (dly_cnt <= DLY_W'(1)) begin
          state_nxt = CHECK;
        end else begin
          dly_cnt_nxt = dly_cnt - DLY_W'(1);
        end
      end
      CHECK:   state_nxt = CHECK;
      default: state_nxt = RST_STATE;
    endcase
  end

  // ARMED comes straight from the state flop, so it is registered
  assign armed = (state == CHECK);

  // Per-channel violation detection; data is only inspected on a known-high enable
  always_comb begin
    viol = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (armed) begin
        if ($isunknown(bus.wen[i])) begin
          viol[i] = 1'b1;
        end else if (bus.wen[i] === 1'b1) begin
          if ($isunknown(^bus.d[i*WIDTH +: WIDTH])) begin
            viol[i] = 1'b1;
          end
        end
      end
    end
  end

  // An unknown clear is treated as inactive and reported separately
  always_comb begin
    clr_unknown = $isunknown(bus.clr);
    clr_eff     = (bus.clr === 1'b1);
  end

  // Lowest violating channel index for the first-error record
  always_comb begin
    low_idx = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (viol[i]) begin
        low_idx = CH_W'(i);
      end
    end
  end

  // Status next-state: clear first, then fold in this cycle's violations
  always_comb begin
    vld_nxt       = clr_eff ? '0   : vld_q;
    first_vld_nxt = clr_eff ? 1'b0 : first_vld_q;
    first_ch_nxt  = clr_eff ? '0   : first_ch_q;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_nxt[i] = clr_eff ? '0 : cnt_q[i];
      if (viol[i]) begin
        vld_nxt[i] = 1'b1;
        if (cnt_nxt[i] != CNT_MAX) begin
          cnt_nxt[i] = cnt_nxt[i] + CNT_W'(1);
        end
      end
    end
    if (!first_vld_nxt && (|viol)) begin
      first_vld_nxt = 1'b1;
      first_ch_nxt  = low_idx;
    end
  end

  // Status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q       <= '0;
      first_vld_q <= 1'b0;
      first_ch_q  <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      vld_q       <= vld_nxt;
      first_vld_q <= first_vld_nxt;
      first_ch_q  <= first_ch_nxt;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_nxt[i];
      end
    end
  end

  // Error reporting, one message per violating channel, silent until armed
  always_ff @(posedge clk) begin
    if (rst_n && armed) begin
      if (clr_unknown) begin
        `MCASH_ASSERT_ERROR($sformatf("dff_xchecker_mc: clr is unknown, treated as 0"));
      end
      for (int i = 0; i < CHANNELS; i++) begin
        if (viol[i]) begin
          `MCASH_ASSERT_ERROR($sformatf("dff_xchecker_mc: unknown write on channel %0d", i));
        end
      end
    end
  end

  assign bus.armed     = armed;
  assign bus.err_vld   = vld_q;
  assign bus.first_vld = first_vld_q;
  assign bus.first_ch  = first_ch_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_cnt_out
    assign bus.err_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end

endmodule

// File: tb/tb_dff_xchecker_mc.sv
// Testbench for dff_xchecker_mc: directed scenarios followed by randomized
// traffic with sporadic unknowns, clears and resets. A reference model
// predicts the status after every edge and queues it; a monitor compares.
module tb_dff_xchecker_mc;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 4;
  localparam int ARM_DLY  = 4;
  localparam int CNT_W    = 2;
  localparam int CMAX     = (1 << CNT_W) - 1;

  typedef struct packed {
    logic       armed;
    logic [3:0] vld;
    logic [7:0] cnt;
    logic       fvld;
    logic [1:0] fch;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  dff_xchecker_mc_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .CNT_W(CNT_W)) bus ();

  dff_xchecker_mc #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .ARM_DLY(ARM_DLY), .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // reference model state
  int         m_edges;
  logic [3:0] m_vld;
  int         m_cnt[4];
  logic       m_fvld;
  int         m_fch;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_clear();
    m_vld  = '0;
    m_fvld = 1'b0;
    m_fch  = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  // drive one cycle of stimulus and queue the status expected after the edge
  task automatic step(input logic [3:0] w, input logic [31:0] dd, input logic c, input bit r);
    exp_t     e;
    bit       armed_before;
    bit [3:0] viol;
    @(negedge clk);
    bus.wen = w;
    bus.d   = dd;
    bus.clr = c;
    rst_n   = r;
    if (!r) begin
      m_edges = 0;
      model_clear();
    end else begin
      armed_before = (m_edges >= ARM_DLY);
      viol = '0;
      for (int i = 0; i < 4; i++) begin
        if (armed_before &&
            ($isunknown(w[i]) || (w[i] === 1'b1 && $isunknown(dd[i*8 +: 8]))))
          viol[i] = 1'b1;
      end
      if (c === 1'b1) model_clear();
      for (int i = 0; i < 4; i++) begin
        if (viol[i]) begin
          m_vld[i] = 1'b1;
          m_cnt[i] = (m_cnt[i] + 1 > CMAX) ? CMAX : m_cnt[i] + 1;
        end
      end
      if (!m_fvld && viol != 4'b0) begin
        m_fvld = 1'b1;
        for (int i = 3; i >= 0; i--) if (viol[i]) m_fch = i;
      end
      if (m_edges < 1000) m_edges++;
    end
    e.armed = (ARM_DLY == 0) || (m_edges >= ARM_DLY);
    e.vld   = m_vld;
    for (int i = 0; i < 4; i++) e.cnt[i*2 +: 2] = 2'(m_cnt[i]);
    e.fvld  = m_fvld;
    e.fch   = 2'(m_fch);
    exp_q.push_back(e);
  endtask

  function automatic logic [7:0] rbyte();
    logic [7:0] b;
    b = 8'($urandom);
    if ($urandom_range(0, 5) == 0) b[$urandom_range(0, 7)] = 1'bx;
    return b;
  endfunction

  // monitor: compare every post-edge sample against the queued prediction
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("armed",     32'(bus.armed),     32'(e.armed));
        check("err_vld",   32'(bus.err_vld),   32'(e.vld));
        check("err_cnt",   32'(bus.err_cnt),   32'(e.cnt));
        check("first_vld", 32'(bus.first_vld), 32'(e.fvld));
        check("first_ch",  32'(bus.first_ch),  32'(e.fch));
      end
    end
  end

  // reset must clear status without waiting for a clock edge
  initial begin
    forever begin
      @(negedge rst_n);
      #1;
      check("async_armed",     32'(bus.armed),     32'(ARM_DLY == 0));
      check("async_err_vld",   32'(bus.err_vld),   32'h0);
      check("async_err_cnt",   32'(bus.err_cnt),   32'h0);
      check("async_first_vld", 32'(bus.first_vld), 32'h0);
      check("async_first_ch",  32'(bus.first_ch),  32'h0);
    end
  end

  initial begin
    logic [31:0] dx;
    logic [31:0] dd;
    logic [7:0]  nib;
    logic [3:0]  wx;
    int          budget;
    m_edges = 0;
    model_clear();
    bus.wen = '0;
    bus.d   = '0;
    bus.clr = 1'b0;
    dx = 'x;

    repeat (2) step(4'h0, 32'h0, 1'b0, 1'b0);

    // warm-up: all channels writing unknown data from reset release
    repeat (9) step(4'hF, dx, 1'b0, 1'b1);

    // fresh reset, clean warm-up
    step(4'h0, 32'h0, 1'b0, 1'b0);
    repeat (ARM_DLY + 1) step(4'h0, 32'h0, 1'b0, 1'b1);

    // qualification: ch1 disabled with X data, ch3 enabled with partial X
    dd = 32'h0;
    dd[15:8] = 'x;
    nib = 8'h00;
    nib[3:0] = 'x;
    dd[31:24] = nib;
    step(4'b1010 & 4'b1000, dd, 1'b0, 1'b1);
    step(4'h0, 32'h0, 1'b0, 1'b1);

    // simultaneous ch0+ch2, then ch1; first record stays on ch0
    step(4'h0, 32'h0, 1'b1, 1'b1);
    dd = 32'h0;
    dd[7:0]   = 'x;
    dd[23:16] = 'x;
    step(4'b0101, dd, 1'b0, 1'b1);
    dd = 32'h0;
    dd[15:8] = 'x;
    step(4'b0010, dd, 1'b0, 1'b1);
    step(4'h0, 32'h0, 1'b0, 1'b1);

    // saturation on ch0
    step(4'h0, 32'h0, 1'b1, 1'b1);
    dd = 32'h0;
    dd[7:0] = 'x;
    repeat (6) step(4'b0001, dd, 1'b0, 1'b1);

    // clear coinciding with a ch2 violation, then reset mid-stream
    dd = 32'h0;
    dd[23:16] = 'x;
    step(4'b0100, dd, 1'b1, 1'b1);
    step(4'b0100, dd, 1'b0, 1'b1);
    step(4'hF, dx, 1'b0, 1'b0);
    repeat (ARM_DLY + 2) step(4'hF, dx, 1'b0, 1'b1);

    // unknown write enable on ch1
    step(4'h0, 32'h0, 1'b1, 1'b1);
    wx = 4'b0000;
    wx[1] = 1'bx;
    step(wx, 32'h0, 1'b0, 1'b1);
    step(4'h0, 32'h0, 1'b0, 1'b1);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [3:0]  w;
      logic [31:0] rd;
      logic        c;
      bit          r;
      int          k;
      for (int i = 0; i < 4; i++) begin
        k = $urandom_range(0, 9);
        if (k == 0)      w[i] = 1'bx;
        else if (k <= 5) w[i] = 1'b1;
        else             w[i] = 1'b0;
        rd[i*8 +: 8] = rbyte();
      end
      k = $urandom_range(0, 31);
      if (k == 0)      c = 1'bx;
      else if (k <= 2) c = 1'b1;
      else             c = 1'b0;
      r = ($urandom_range(0, 99) != 0);
      step(w, rd, c, r);
    end

    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d predictions left unchecked, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dff_xchecker_mc.md
DFF_XCHECKER_MC -- requirements
Module: dff_xchecker_mc

Interface
REQ-001 Parameter WIDTH, default 32: data bits per channel, at least 1.
REQ-002 Parameter CHANNELS, default 4: number of independently checked write channels, at least 1.
REQ-003 Parameter ARM_DLY, default 4: cycles after reset release during which checking is suppressed, at least 0.
REQ-004 Parameter CNT_W, default 8: width of each per-channel error counter, at least 1.
REQ-005 CLK  input  1: single clock; all state updates on posedge.
REQ-006 RST_N  input  1: asynchronous, active-low reset.
REQ-007 WEN  input  CHANNELS: per-channel write enable; bit i qualifies channel i.
REQ-008 D  input  CHANNELS*WIDTH: channel i data occupies D[i*WIDTH +: WIDTH].
REQ-009 CLR  input  1: synchronous clear of all error status.
REQ-010 ARMED  output  1: high when checking is active.
REQ-011 ERR_VLD  output  CHANNELS: sticky per-channel error flag.
REQ-012 ERR_CNT  output  CHANNELS*CNT_W: per-channel saturating violation count; channel i occupies [i*CNT_W +: CNT_W].
REQ-013 FIRST_VLD  output  1: first-error record valid.
REQ-014 FIRST_CH  output  max(1,$clog2(CHANNELS)): channel index of the first recorded violation.

Function
REQ-015 The FSM SHALL have two states, WARMUP and CHECK.
- WARMUP: a down-counter is loaded with ARM_DLY and decrements each cycle; the FSM moves to CHECK on the edge where the counter equals 1.
- If ARM_DLY equals 0, the FSM resets directly into CHECK.
- CHECK is terminal until reset.
REQ-016 ARMED SHALL equal (state==CHECK) and SHALL be registered.
REQ-017 Channel i SHALL violate in a cycle only when ARMED=1 and either condition holds:
- WEN[i] is X or Z;
- WEN[i]===1 and ^D[i*WIDTH +: WIDTH] is X.
REQ-018 With WEN[i]===0, D SHALL NOT be checked.
REQ-019 Violations SHALL be registered with latency 1: ERR_VLD[i] and ERR_CNT[i] reflect a violation sampled at edge N from edge N onward.
REQ-020 ERR_VLD[i] SHALL set on a violation and hold until CLR or reset.
REQ-021 ERR_CNT[i] SHALL increment by 1 per violating cycle and saturate at 2^CNT_W-1, with no wrap.
REQ-022 When FIRST_VLD=0 and at least one channel violates, FIRST_VLD SHALL set and FIRST_CH SHALL capture the lowest violating index.
REQ-023 While FIRST_VLD=1, FIRST_CH SHALL hold.
REQ-024 CLR=1 at an edge SHALL clear ERR_VLD, ERR_CNT, FIRST_VLD and FIRST_CH, then apply that same cycle's violations.
- Example: CLR together with a channel-2 violation leaves ERR_CNT[2]=1, ERR_VLD[2]=1, FIRST_CH=2.
REQ-025 CLR SHALL NOT affect the FSM.
REQ-026 A CLR sampled as X or Z SHALL be treated as 0 and SHALL raise an error through `mcash_assert_error`.
REQ-027 Each violating channel in a cycle SHALL produce one `mcash_assert_error` message naming the channel index.
REQ-028 No message SHALL be produced while ARMED=0.
REQ-029 The block SHALL be simulation-only and SHALL have no effect on the design under check.

Reset
REQ-030 RST_N low SHALL asynchronously force:
- ERR_VLD=0, ERR_CNT=0, FIRST_VLD=0, FIRST_CH=0;
- state=WARMUP with the counter loaded to ARM_DLY (state=CHECK if ARM_DLY=0);
- ARMED=0, or ARMED=1 if ARM_DLY=0.
REQ-031 Reset asserted mid-operation SHALL discard all status, restart the warm-up, and suppress checking until ARMED rises again.
REQ-032 Violations present in the cycle of reset release SHALL be ignored whenever ARM_DLY>0.

Verification
REQ-033 Warm-up: ARM_DLY=4, WEN=all 1, D all X from reset release -> ARMED rises on the 4th edge; ERR_CNT stays 0 until ARMED=1, then increments by 1 per cycle on every channel.
REQ-034 Qualification: channel 1 with WEN=0 and D=X, channel 3 with WEN=1 and D=8'h0X -> ERR_VLD=4'b1000, FIRST_CH=3, no error reported for channel 1.
REQ-035 Simultaneous and order: channels 2 and 0 violate in the same cycle, then channel 1 violates -> FIRST_CH=0 and held; ERR_VLD=4'b0111.
REQ-036 Saturation: CNT_W=2, channel 0 violates for 6 cycles -> ERR_CNT[0] sequence 1,2,3,3,3,3.
REQ-037 Clear and reset: CLR together with a channel-2 violation -> ERR_CNT[2]=1, FIRST_CH=2; then RST_N pulsed low mid-stream -> all outputs 0 immediately and ARMED=0 for ARM_DLY cycles after release.
REQ-038 X on WEN: WEN[1]=X while armed -> ERR_VLD[1]=1 and ERR_CNT[1]=1 on the next edge.
